// File: rtl/fetch_tracker.sv
// fetch_tracker: pairs granted fetches with their rvalid responses and emits timestamped trace records.
// Optional FETCH_TRACKER_STALL_COUNT_EN adds gnt_stall_o, the REQ_WAIT cycle count of each fetch.
module fetch_tracker #(
    parameter int OUTSTANDING = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           counter,
    input  logic                  instr_req,
    input  logic                  instr_gnt,
    input  logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic                  instr_rvalid,
    input  logic [DATA_WIDTH-1:0] instr_rdata,
    output logic [ADDR_WIDTH-1:0] if_addr_o,
    output logic [DATA_WIDTH-1:0] if_instr_o,
    output logic [31:0]           if_stage_start_o,
    output logic [31:0]           if_stage_end_o,
    output logic                  if_data_ready,
    output logic                  overflow_o,
    output logic                  spurious_o
`ifdef FETCH_TRACKER_STALL_COUNT_EN
    ,
    output logic [15:0]           gnt_stall_o
`endif
);
    localparam int PW = OUTSTANDING > 1 ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING) + 1;

    typedef enum logic {IDLE, REQ_WAIT} state_t;
    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] addr_mem [OUTSTANDING];
    logic [31:0]           start_mem [OUTSTANDING];
    logic [31:0]           start_q, start_time;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         occ;
    logic                  gnt, empty, full, push, pop, bypass;

    assign gnt    = instr_req & instr_gnt;
    assign empty  = occ == '0;
    assign full   = occ == CW'(OUTSTANDING);
    assign bypass = gnt & instr_rvalid & empty;
    assign pop    = instr_rvalid & ~empty;
    assign push   = gnt & ~bypass & (~full | instr_rvalid);

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_nxt  = (instr_req && !instr_gnt) ? REQ_WAIT : IDLE;
        start_time = (state == REQ_WAIT) ? start_q : counter;
    end

`ifdef FETCH_TRACKER_STALL_COUNT_EN
    logic [15:0] stall_mem [OUTSTANDING];
    logic [15:0] stall_q, stall_val;
    // Counts the grant cycle itself, so a 3-cycle wait reports 3.
    assign stall_val = (state != REQ_WAIT) ? 16'd0 : (&stall_q) ? stall_q : stall_q + 16'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q     <= '0;
            gnt_stall_o <= '0;
        end else begin
            stall_q <= stall_val;
            if (pop || bypass) gnt_stall_o <= pop ? stall_mem[rd_ptr] : stall_val;
        end
    end

    always_ff @(posedge clk)
        if (rst_n && push) stall_mem[wr_ptr] <= stall_val;
`endif

    always_ff @(posedge clk)
        if (rst_n && push) begin
            addr_mem[wr_ptr]  <= instr_addr;
            start_mem[wr_ptr] <= start_time;
        end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            start_q          <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            occ              <= '0;
            if_addr_o        <= '0;
            if_instr_o       <= '0;
            if_stage_start_o <= '0;
            if_stage_end_o   <= '0;
            if_data_ready    <= 1'b0;
            overflow_o       <= 1'b0;
            spurious_o       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) start_q <= counter;
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop) rd_ptr <= inc(rd_ptr);
            occ           <= occ + CW'(push) - CW'(pop);
            overflow_o    <= overflow_o | (gnt & full & ~instr_rvalid);
            spurious_o    <= spurious_o | (instr_rvalid & empty & ~gnt);
            if_data_ready <= pop | bypass;
            // A bypassed fetch never waited in the queue, so its start equals its end.
            if (pop || bypass) begin
                if_addr_o        <= pop ? addr_mem[rd_ptr] : instr_addr;
                if_instr_o       <= instr_rdata;
                if_stage_start_o <= pop ? start_mem[rd_ptr] : counter;
                if_stage_end_o   <= counter;
            end
        end
    end
endmodule

// File: tb/tb_fetch_tracker.sv
// tb_fetch_tracker: directed and random fetch traffic checked against a queue-based reference model.
module tb_fetch_tracker;
    localparam int OUT = 2;

    logic        clk = 0, rst_n = 0, instr_req = 0, instr_gnt = 0, instr_rvalid = 0;
    logic [31:0] counter = 0, instr_addr = 0, instr_rdata = 0;
    logic [31:0] if_addr_o, if_instr_o, if_stage_start_o, if_stage_end_o;
    logic        if_data_ready, overflow_o, spurious_o;
`ifdef FETCH_TRACKER_STALL_COUNT_EN
    logic [15:0] gnt_stall_o;
`endif

    fetch_tracker #(.OUTSTANDING(OUT), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .counter(counter),
        .instr_req(instr_req), .instr_gnt(instr_gnt), .instr_addr(instr_addr),
        .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata),
        .if_addr_o(if_addr_o), .if_instr_o(if_instr_o),
        .if_stage_start_o(if_stage_start_o), .if_stage_end_o(if_stage_end_o),
        .if_data_ready(if_data_ready), .overflow_o(overflow_o), .spurious_o(spurious_o)
`ifdef FETCH_TRACKER_STALL_COUNT_EN
        , .gnt_stall_o(gnt_stall_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; logic [31:0] st; int sc;} ent_t;
    ent_t q[$];

    int          n_tests = 0, n_fail = 0;
    logic [31:0] cnt = 0;
    bit          waiting = 0;
    logic [31:0] wstart = 0;
    int          wcount = 0;
    logic [31:0] e_addr, e_instr, e_start, e_end;
    bit          e_rdy, e_ovf, e_spur;
    int          e_stall;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (counter %0d)", tag, got, exp, counter);
        end
    endtask

    task automatic model_clear();
        q.delete();
        waiting = 0; wcount = 0; wstart = 0;
        {e_addr, e_instr, e_start, e_end} = '0;
        {e_rdy, e_ovf, e_spur} = '0;
        e_stall = 0;
    endtask

    // One clock: drive at the falling edge, predict, check 1 time unit after the rising edge.
    task automatic step(input bit rs, input bit rq, input bit gn, input logic [31:0] ad,
                        input bit rv, input logic [31:0] rd);
        logic [31:0] st;
        int          sc;
        bit          g;
        ent_t        e;
        @(negedge clk);
        rst_n = rs; instr_req = rq; instr_gnt = gn; instr_addr = ad;
        instr_rvalid = rv; instr_rdata = rd; counter = cnt;
        g = rq && gn;
        if (!rs) model_clear();
        else begin
            st = waiting ? wstart : cnt;
            sc = waiting ? wcount : 0;
            if (rq && !gn) begin
                wstart = st; wcount = sc + 1; waiting = 1;
            end else waiting = 0;
            e_rdy = 0;
            if (rv && q.size() > 0) begin
                e = q.pop_front();
                e_rdy = 1; e_addr = e.addr; e_instr = rd; e_start = e.st; e_end = cnt; e_stall = e.sc;
                if (g) q.push_back('{ad, st, sc});
            end else if (rv && g) begin
                e_rdy = 1; e_addr = ad; e_instr = rd; e_start = cnt; e_end = cnt; e_stall = sc;
            end else if (rv) e_spur = 1;
            else if (g) begin
                if (q.size() == OUT) e_ovf = 1;
                else q.push_back('{ad, st, sc});
            end
        end
        @(posedge clk);
        #1;
        check("ready", if_data_ready, e_rdy);
        check("addr", if_addr_o, e_addr);
        check("instr", if_instr_o, e_instr);
        check("start", if_stage_start_o, e_start);
        check("end", if_stage_end_o, e_end);
        check("overflow", overflow_o, e_ovf);
        check("spurious", spurious_o, e_spur);
`ifdef FETCH_TRACKER_STALL_COUNT_EN
        check("stall", gnt_stall_o, 64'(e_stall > 65535 ? 65535 : e_stall));
`endif
        cnt++;
    endtask

    initial begin
        model_clear();
        step(0, 1, 1, 32'h44, 1, 32'h55);
        step(0, 0, 0, 0, 0, 0);
        check("rst_ready", if_data_ready, 0);
        check("rst_addr", if_addr_o, 0);

        // single fetch
        cnt = 10;
        step(1, 1, 1, 32'h80, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 32'h00002083);
        check("d36_ready", if_data_ready, 1);
        check("d36_addr", if_addr_o, 32'h80);
        check("d36_start", if_stage_start_o, 10);
        check("d36_end", if_stage_end_o, 12);
        step(1, 0, 0, 0, 0, 0);
        check("d36_once", if_data_ready, 0);
        check("d36_hold", if_instr_o, 32'h00002083);

        // grant wait
        cnt = 20;
        step(1, 1, 0, 32'h90, 0, 0);
        step(1, 1, 0, 32'h90, 0, 0);
        step(1, 1, 0, 32'h90, 0, 0);
        step(1, 1, 1, 32'h90, 0, 0);
        step(1, 0, 0, 0, 1, 32'h1234);
        check("d37_start", if_stage_start_o, 20);
        check("d37_end", if_stage_end_o, 24);
`ifdef FETCH_TRACKER_STALL_COUNT_EN
        check("d37_stall", gnt_stall_o, 3);
`endif

        // pipelined
        cnt = 30;
        step(1, 1, 1, 32'h100, 0, 0);
        step(1, 1, 1, 32'h104, 1, 32'hA);
        check("d38_first", if_addr_o, 32'h100);
        step(1, 0, 0, 0, 1, 32'hB);
        check("d38_second", if_addr_o, 32'h104);
        check("d38_start", if_stage_start_o, 31);
        check("d38_end", if_stage_end_o, 32);

        // overflow
        step(1, 1, 1, 32'h200, 0, 0);
        step(1, 1, 1, 32'h204, 0, 0);
        step(1, 1, 1, 32'h208, 0, 0);
        check("d39_ovf", overflow_o, 1);
        step(1, 0, 0, 0, 1, 32'h1);
        check("d39_a0", if_addr_o, 32'h200);
        step(1, 0, 0, 0, 1, 32'h2);
        check("d39_a1", if_addr_o, 32'h204);

        // bypass, spurious, reset with a pending entry
        step(1, 1, 1, 32'h300, 1, 32'h3);
        check("bypass_addr", if_addr_o, 32'h300);
        check("bypass_spur", spurious_o, 0);
        step(1, 0, 0, 0, 1, 32'h4);
        check("d40_spur", spurious_o, 1);
        check("d40_nostrobe", if_data_ready, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 32'h400, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 32'h5);
        check("d40_rst_spur", spurious_o, 1);
        check("d40_rst_nostrobe", if_data_ready, 0);

        for (int i = 0; i < 3000; i++) begin
            bit rq;
            rq = $urandom_range(0, 9) < 7;
            step($urandom_range(0, 99) != 0, rq, rq && ($urandom_range(0, 1) == 1),
                 $urandom, $urandom_range(0, 9) < 4, $urandom);
            if (cnt > 32'hFFFF_FF00) cnt = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
